// File: rtl/frame_buffer_ctrl.sv
// Ping-pong two-bank frame buffer: a pixel stream fills one bank while a completed frame streams out of the other.
// Define FRAME_BUF_OUT_REG_EN to add an output register stage (read latency 3 instead of 2).
module frame_buffer_ctrl #(
  parameter int PIX_WIDTH = 8,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iWrValid,
  input  logic                 iWrSof,
  input  logic [PIX_WIDTH-1:0] iWrData,
  output logic                 oWrReady,
  input  logic                 iRdStart,
  output logic                 oRdBusy,
  output logic                 oFrameReady,
  output logic                 oRdValid,
  output logic [PIX_WIDTH-1:0] oRdData,
  output logic                 oRdSof,
  output logic                 oRdEol,
  output logic                 oRdEof
);
  localparam int DEPTH = H_ACTIVE * V_ACTIVE;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int RW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(H_ACTIVE - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(V_ACTIVE - 1);
  localparam logic [AW:0]   BANK_OFS = (AW+1)'(DEPTH);

  localparam logic [0:0] W_SYNC  = 1'b0;
  localparam logic [0:0] W_FILL  = 1'b1;
  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_RUN   = 2'd1;
  localparam logic [1:0] R_DRAIN = 2'd2;

  function automatic logic [AW:0] f_phys(input logic bank, input logic [AW-1:0] ptr);
    return bank ? (BANK_OFS + {1'b0, ptr}) : {1'b0, ptr};
  endfunction

  logic [PIX_WIDTH-1:0] r_mem [2*DEPTH];

  logic [1:0]           r_full;
  logic [1:0]           w_full_nxt;
  logic                 r_wr_bank;
  logic                 r_rd_bank;
  logic                 r_frame_ready;

  logic [0:0]           r_wr_state;
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        w_wr_ptr;
  logic [AW:0]          w_waddr;
  logic                 w_wr_ready;
  logic                 w_accept;
  logic                 w_we;
  logic                 w_wr_done;

  logic [1:0]           r_rd_state;
  logic [AW-1:0]        r_raddr;
  logic [CW-1:0]        r_col;
  logic [RW-1:0]        r_row;
  logic [AW:0]          w_raddr;
  logic                 w_issue;
  logic                 w_rd_done;

  logic [PIX_WIDTH-1:0] r_mem_q;
  logic                 r_s1_valid, r_s1_sof, r_s1_eol, r_s1_eof;
  logic [PIX_WIDTH-1:0] r_s2_data;
  logic                 r_s2_valid, r_s2_sof, r_s2_eol, r_s2_eof;
  logic                 w_out_valid;
  logic                 w_out_eof;

  // ---------------- write side ----------------
  assign w_wr_ready = ~iRst & ~r_full[r_wr_bank];
  assign w_accept   = iWrValid & w_wr_ready;
  assign w_we       = w_accept & (iWrSof | (r_wr_state == W_FILL));
  assign w_wr_ptr   = iWrSof ? '0 : r_wr_ptr;
  assign w_waddr    = f_phys(r_wr_bank, w_wr_ptr);
  assign w_wr_done  = w_accept & ~iWrSof & (r_wr_state == W_FILL) & (r_wr_ptr == LAST_PTR);
  assign oWrReady   = w_wr_ready;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_wr_state <= W_SYNC;
      r_wr_ptr   <= '0;
    end else if (w_accept) begin
      if (iWrSof) begin
        r_wr_ptr   <= AW'(1);
        r_wr_state <= W_FILL;
      end else if (r_wr_state == W_FILL) begin
        if (r_wr_ptr == LAST_PTR) begin
          r_wr_ptr   <= '0;
          r_wr_state <= W_SYNC;
        end else begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
      end
    end
  end

  // ---------------- bank bookkeeping ----------------
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_done) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_rd_done) w_full_nxt[r_rd_bank] = 1'b0;
  end

  // Writer hops using next-cycle fullness so a bank freed this cycle is usable immediately.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_full        <= '0;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_frame_ready <= 1'b0;
    end else begin
      r_full        <= w_full_nxt;
      r_frame_ready <= |r_full;
      if (w_full_nxt[r_wr_bank] && !w_full_nxt[~r_wr_bank]) r_wr_bank <= ~r_wr_bank;
      if (w_rd_done) r_rd_bank <= ~r_rd_bank;
    end
  end

  // ---------------- frame memory ----------------
  always_ff @(posedge iClk) begin
    if (w_we) r_mem[w_waddr] <= iWrData;
    if (w_issue) r_mem_q <= r_mem[w_raddr];
  end

  // ---------------- read side ----------------
  assign w_issue = (r_rd_state == R_RUN);
  assign w_raddr = f_phys(r_rd_bank, r_raddr);
  assign oRdBusy = (r_rd_state != R_IDLE);
  assign w_rd_done = w_out_valid & w_out_eof;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_rd_state <= R_IDLE;
      r_raddr    <= '0;
      r_col      <= '0;
      r_row      <= '0;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (iRdStart && r_full[r_rd_bank]) begin
            r_rd_state <= R_RUN;
            r_raddr    <= '0;
            r_col      <= '0;
            r_row      <= '0;
          end
        end
        R_RUN: begin
          r_raddr <= r_raddr + AW'(1);
          if (r_col == LAST_COL) begin
            r_col <= '0;
            r_row <= r_row + RW'(1);
          end else begin
            r_col <= r_col + CW'(1);
          end
          if (r_raddr == LAST_PTR) r_rd_state <= R_DRAIN;
        end
        R_DRAIN: begin
          if (w_rd_done) r_rd_state <= R_IDLE;
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  // Markers travel alongside the memory read so they line up with r_mem_q.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_s1_valid <= 1'b0;
      r_s1_sof   <= 1'b0;
      r_s1_eol   <= 1'b0;
      r_s1_eof   <= 1'b0;
    end else begin
      r_s1_valid <= w_issue;
      r_s1_sof   <= w_issue && (r_col == '0) && (r_row == '0);
      r_s1_eol   <= w_issue && (r_col == LAST_COL);
      r_s1_eof   <= w_issue && (r_col == LAST_COL) && (r_row == LAST_ROW);
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_s2_data  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_sof   <= 1'b0;
      r_s2_eol   <= 1'b0;
      r_s2_eof   <= 1'b0;
    end else begin
      if (r_s1_valid) r_s2_data <= r_mem_q;
      r_s2_valid <= r_s1_valid;
      r_s2_sof   <= r_s1_sof;
      r_s2_eol   <= r_s1_eol;
      r_s2_eof   <= r_s1_eof;
    end
  end

`ifdef FRAME_BUF_OUT_REG_EN
  logic [PIX_WIDTH-1:0] r_s3_data;
  logic                 r_s3_valid, r_s3_sof, r_s3_eol, r_s3_eof;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_s3_data  <= '0;
      r_s3_valid <= 1'b0;
      r_s3_sof   <= 1'b0;
      r_s3_eol   <= 1'b0;
      r_s3_eof   <= 1'b0;
    end else begin
      if (r_s2_valid) r_s3_data <= r_s2_data;
      r_s3_valid <= r_s2_valid;
      r_s3_sof   <= r_s2_sof;
      r_s3_eol   <= r_s2_eol;
      r_s3_eof   <= r_s2_eof;
    end
  end

  assign oRdData     = r_s3_data;
  assign oRdValid    = r_s3_valid;
  assign oRdSof      = r_s3_sof;
  assign oRdEol      = r_s3_eol;
  assign oRdEof      = r_s3_eof;
  assign w_out_valid = r_s3_valid;
  assign w_out_eof   = r_s3_eof;
`else
  assign oRdData     = r_s2_data;
  assign oRdValid    = r_s2_valid;
  assign oRdSof      = r_s2_sof;
  assign oRdEol      = r_s2_eol;
  assign oRdEof      = r_s2_eof;
  assign w_out_valid = r_s2_valid;
  assign w_out_eof   = r_s2_eof;
`endif

  assign oFrameReady = r_frame_ready;

endmodule

// File: doc/frame_buffer_ctrl.md
# frame_buffer_ctrl

Parametrised double-buffered (ping-pong) frame buffer between a pixel source (camera/preprocess) and the downstream processing pipeline. An input pixel stream is written into one of two internal frame banks inferred as simple dual-port block RAM, while a completed frame is streamed out of the other bank with raster markers. Frame geometry, pixel width and read latency are configurable, generalising the fixed 640x480x8 single-buffer BRAM interface.

## Interface
- PIX_WIDTH, 8, pixel width in bits
- H_ACTIVE, 640, pixels per line
- V_ACTIVE, 480, lines per frame
- (derived) DEPTH = H_ACTIVE*V_ACTIVE; AW = clog2(DEPTH); memory holds 2*DEPTH words
- iClk  in  1  clock; all logic on rising edge
- iRst  in  1  reset, synchronous, active-high
- iWrValid  in  1  input pixel valid
- iWrSof  in  1  input pixel is first of frame (qualified by iWrValid)
- iWrData  in  PIX_WIDTH  input pixel
- oWrReady  out  1  writer can accept a pixel
- iRdStart  in  1  single-cycle request to stream one stored frame
- oRdBusy  out  1  read frame in progress
- oFrameReady  out  1  at least one bank holds a complete unread frame
- oRdValid  out  1  output pixel valid
- oRdData  out  PIX_WIDTH  output pixel
- oRdSof / oRdEol / oRdEof  out  1 each  first pixel of frame / last pixel of line / last pixel of frame (valid only with oRdValid)

## Operation
- Bank state: full[1:0], wr_bank, rd_bank; both bank pointers reset to 0. Physical address = bank ? DEPTH+ptr : ptr.
- Accept = iWrValid & oWrReady. oWrReady = ~full[wr_bank].
- Write FSM: W_SYNC -> W_FILL.
  - W_SYNC: accepted pixels without iWrSof are discarded; accepted pixel with iWrSof is written to ptr 0, ptr=1, go W_FILL.
  - W_FILL: each accept writes at ptr, ptr++. An accepted iWrSof pixel in W_FILL restarts at ptr 0 (partial frame abandoned, bank stays not-full).
  - Accept at ptr DEPTH-1: full[wr_bank]<=1, ptr<=0, go W_SYNC; wr_bank toggles to the other bank if that bank is not full in the same cycle, else stays and oWrReady stays low until it is freed, then wr_bank toggles.
- Read FSM: R_IDLE -> R_RUN -> R_DRAIN -> R_IDLE.
  - R_IDLE: iRdStart with full[rd_bank]=1 -> R_RUN, raddr=0. iRdStart otherwise ignored.
  - R_RUN: one read address per cycle, raddr 0..DEPTH-1, no backpressure; after DEPTH-1 issued -> R_DRAIN.
  - R_DRAIN: when the last pixel (oRdEof) is output: full[rd_bank]<=0, rd_bank toggles, -> R_IDLE.
  - iRdStart during R_RUN/R_DRAIN ignored.
- Banks alternate strictly: writer and reader both start on bank 0 and toggle per completed frame, so frames are read in write order.
- Output markers from col/row counters pipelined with the data: oRdSof at pixel 0, oRdEol at col H_ACTIVE-1, oRdEof at pixel DEPTH-1.
- Simultaneous write-complete on one bank and read-free of the other in the same cycle: both take effect; writer moves to freed bank next cycle.

## Timing
- Reset: oWrReady=0, oRdBusy=0, oFrameReady=0, oRdValid=0, oRdData=0, oRdSof/Eol/Eof=0; full=0, FSMs W_SYNC/R_IDLE. oWrReady=1 the first cycle after iRst deasserts.
- Reset mid-frame discards all stored and partial frames.
- Read latency L (iRdStart edge to first oRdValid): L=2 cycles, L=3 with output register (see Configuration). Then oRdValid high for exactly DEPTH consecutive cycles.
- oRdBusy high from cycle after accepted iRdStart through the cycle oRdEof is output.
- oFrameReady = |full, registered (updates one cycle after full changes).
- Write throughput 1 pixel/cycle; a write is visible to a read of the same bank only after the bank is marked full.

## Configuration
- FRAME_BUF_OUT_REG_EN defined: extra output register after BRAM read data (and markers), read latency L=3, matches HIGH_PERFORMANCE BRAM.
- Not defined: data taken directly from BRAM read register, L=2.

## Test plan
- H=4,V=2: reset, write 8 pixels 0x10..0x17 with iWrSof on first, iRdStart -> oFrameReady=1, oRdData 0x10..0x17 on 8 consecutive cycles starting L cycles after start, oRdSof on 0x10, oRdEol on 0x13/0x17, oRdEof on 0x17.
- Write two frames (A=0x20.., B=0x30..) with no read -> oWrReady=0 after 16th accept; third frame stalled; read twice -> frame A then B; oWrReady=1 the cycle after A's oRdEof.
- 3 pixels without iWrSof then full frame with iWrSof -> first 3 discarded; readback equals the SOF frame only.
- iWrSof reasserted at ptr 5 of a frame -> partial discarded, new frame starting at that pixel read back intact.
- iRdStart with no full bank, and iRdStart while busy -> ignored; no oRdValid, frame count unchanged.
- Assert iRst mid-read (pixel 3) -> oRdValid=0 next cycle, oFrameReady=0, oWrReady=1 after release; rebuild with and without FRAME_BUF_OUT_REG_EN to confirm L=3/L=2.
